// File: rtl/score_pkg.sv
// Shared types and BCD helper for the two-player score controller.
// Pure declarations; no state, no latency.
package score_pkg;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  typedef logic [2:0] pend_t;

  localparam logic [7:0] SCORE_MAX = 8'h99;

  // Two-digit BCD increment; caller guarantees the input is below 99.
  function automatic bcd2_t bcd2_inc(input bcd2_t v);
    bcd2_t r;
    r = v;
    if (v.ones == 4'd9) begin
      r.ones = 4'd0;
      r.tens = v.tens + 4'd1;
    end else begin
      r.ones = v.ones + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_score_acc.sv
// Per-player BCD score accumulator: hits fill a saturating pending buffer drained one point per cycle.
// Score moves one edge after a point is pending; no backpressure, excess points beyond PEND_MAX are dropped.
module bcd_score_acc
  import score_pkg::*;
#(
  parameter int PEND_MAX = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       hit_valid,
  input  logic [1:0] hit_pts,
  output bcd2_t      score,
  output logic       busy,
  output logic       sat
);

  pend_t      pend_q;
  pend_t      pend_n;
  bcd2_t      score_n;
  logic       drain;
  logic       at_max;
  logic [3:0] sum;
  logic [3:0] add;

  always_comb begin
    at_max  = (score == SCORE_MAX);
    drain   = (pend_q != 3'd0) && !at_max;
    score_n = drain ? bcd2_inc(score) : score;
    add     = hit_valid ? {2'b00, hit_pts} : 4'd0;
    // drain implies pend_q >= 1, so the subtraction cannot underflow
    sum     = {1'b0, pend_q} - {3'b000, drain} + add;
    if (at_max) begin
      pend_n = 3'd0;
    end else if (sum > 4'(PEND_MAX)) begin
      pend_n = pend_t'(PEND_MAX);
    end else begin
      pend_n = sum[2:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score  <= '0;
      pend_q <= '0;
      busy   <= 1'b0;
      sat    <= 1'b0;
    end else if (clear) begin
      score  <= '0;
      pend_q <= '0;
      busy   <= 1'b0;
      sat    <= 1'b0;
    end else begin
      score  <= score_n;
      pend_q <= pend_n;
      busy   <= (pend_n != 3'd0);
      sat    <= (score_n == SCORE_MAX);
    end
  end

endmodule

// File: rtl/score_scheduler.sv
// Two-player score controller time-sharing one 2-digit display, switching player every DWELL_CYCLES.
// Display word trails internal score by one edge; no backpressure, events are always accepted or dropped.
module score_scheduler
  import score_pkg::*;
#(
  parameter int DWELL_CYCLES = 40_000_000,
  parameter int PEND_MAX     = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic [1:0] hit_valid,
  input  logic [3:0] hit_pts,
  output logic [8:0] score,
  output logic [1:0] busy,
  output logic [1:0] sat
);

  localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

  bcd2_t          score0;
  bcd2_t          score1;
  bcd2_t          shown_score;
  logic [CW-1:0]  dwell_cnt;
  logic           shown;

  bcd_score_acc #(.PEND_MAX(PEND_MAX)) u_acc0 (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .hit_valid (hit_valid[0]),
    .hit_pts   (hit_pts[1:0]),
    .score     (score0),
    .busy      (busy[0]),
    .sat       (sat[0])
  );

  bcd_score_acc #(.PEND_MAX(PEND_MAX)) u_acc1 (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .hit_valid (hit_valid[1]),
    .hit_pts   (hit_pts[3:2]),
    .score     (score1),
    .busy      (busy[1]),
    .sat       (sat[1])
  );

  always_comb begin
    shown_score = shown ? score1 : score0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dwell_cnt <= '0;
      shown     <= 1'b0;
      score     <= 9'h000;
    end else if (clear) begin
      dwell_cnt <= '0;
      shown     <= 1'b0;
      score     <= 9'h000;
    end else begin
      if (dwell_cnt == CW'(DWELL_CYCLES - 1)) begin
        dwell_cnt <= '0;
        shown     <= ~shown;
      end else begin
        dwell_cnt <= dwell_cnt + 1'b1;
      end
      score <= {shown, shown_score};
    end
  end

endmodule
